// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the FSM state encodings, the supported opcodes, the aluop
// encodings consumed by aludec, and a helper that flags supported opcodes.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_RTYPEEX = 4'd6;
    localparam state_t S_ALUWB   = 4'd7;
    localparam state_t S_BREX    = 4'd8;
    localparam state_t S_ADDIEX  = 4'd9;
    localparam state_t S_ADDIWB  = 4'd10;
    localparam state_t S_JEX     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for every opcode the FSM knows how to sequence.
    function automatic logic op_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_BNE, OP_ADDI, OP_J:          legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU function decoder.
// Ports: funct (instr[5:0]), aluop (add/sub/funct-decoded) -> alucontrol.
module aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    // Map aluop (and funct for R-type) to the ALU operation code.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALUOP_ADD: alucontrol = 3'b010;
            ALUOP_SUB: alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;  // add
                    6'b100010: alucontrol = 3'b110;  // sub
                    6'b100100: alucontrol = 3'b000;  // and
                    6'b100101: alucontrol = 3'b001;  // or
                    6'b101010: alucontrol = 3'b111;  // slt
                    default:   alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Main decoder FSM for the multicycle datapath.
// Ports: clk, reset (async, active-high), op, memready in;
// datapath selects/enables, aluop, and pcwrite/branch/bne qualifiers out.
// illegal pulses during DECODE when op is not supported.
module mc_maindec
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       illegal
);

    state_t state_r;
    state_t next_state_s;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; memory states hold until memready.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (memready) next_state_s = S_DECODE;
                else          next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:    next_state_s = S_MEMADR;
                    OP_RTYPE:        next_state_s = S_RTYPEEX;
                    OP_BEQ, OP_BNE:  next_state_s = S_BREX;
                    OP_ADDI:         next_state_s = S_ADDIEX;
                    OP_J:            next_state_s = S_JEX;
                    default:         next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW)      next_state_s = S_MEMWR;
                else if (op == OP_LW) next_state_s = S_MEMRD;
                else                  next_state_s = S_FETCH;
            end
            S_MEMRD: begin
                if (memready) next_state_s = S_MEMWB;
                else          next_state_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (memready) next_state_s = S_FETCH;
                else          next_state_s = S_MEMWR;
            end
            S_RTYPEEX: next_state_s = S_ALUWB;
            S_ADDIEX:  next_state_s = S_ADDIWB;
            default:   next_state_s = S_FETCH;
        endcase
    end

    // Output decode: Moore on state, except the memready-gated FETCH
    // strobes and the op-dependent branch qualifiers / illegal pulse.
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        illegal  = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = ~op_legal(op);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BREX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = (op == OP_BEQ);
                bne     = (op == OP_BNE);
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                alusrcb = 2'b01;
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit top.
// Ports: clk, reset (async, active-high), op/funct from the instruction
// register, zero from the ALU, memready from memory; datapath selects and
// enables, alucontrol for the ALU, and an illegal-opcode pulse.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    logic [1:0] aluop_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       bne_s;

    mc_maindec u_maindec (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .memready (memready),
        .iord     (iord),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop_s),
        .pcwrite  (pcwrite_s),
        .branch   (branch_s),
        .bne      (bne_s),
        .illegal  (illegal)
    );

    aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop_s),
        .alucontrol (alucontrol)
    );

    // Branch taken when beq sees zero or bne sees non-zero.
    assign pcen = pcwrite_s | (branch_s & zero) | (bne_s & ~zero);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction phase sequences
// built from the instruction class, with per-phase expected control words.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;

    logic [5:0] funct_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_tab   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memready(memready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] act_w;
    assign act_w = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                    alusrcb, pcsrc, pcen, alucontrol, illegal};

    function automatic logic is_legal(input logic [5:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) ||
               (o == BNE) || (o == ADDI) || (o == JMP);
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        logic [2:0] r = 3'b000;
        for (int k = 0; k < 5; k++) if (funct_tab[k] == f) r = alu_tab[k];
        return r;
    endfunction

    // Expected control word for one phase of an instruction.
    function automatic logic [15:0] expect_word(input string ph, input logic mr,
                                                input logic z, input logic [5:0] o,
                                                input logic [5:0] f);
        logic e_iord = 0, e_mw = 0, e_irw = 0, e_rd = 0, e_m2r = 0, e_rw = 0;
        logic e_sa = 0, e_pcen = 0, e_ill = 0;
        logic [1:0] e_sb = 2'b00, e_ps = 2'b00;
        logic [2:0] e_alu = 3'b010;
        if (ph == "FETCH") begin e_sb = 2'b01; e_irw = mr; e_pcen = mr; end
        else if (ph == "DECODE") begin e_sb = 2'b11; e_ill = !is_legal(o); end
        else if (ph == "MEMADR" || ph == "ADDIEX") begin e_sa = 1; e_sb = 2'b10; end
        else if (ph == "MEMRD") e_iord = 1;
        else if (ph == "MEMWB") begin e_m2r = 1; e_rw = 1; end
        else if (ph == "MEMWR") begin e_iord = 1; e_mw = 1; end
        else if (ph == "RTYPEEX") begin e_sa = 1; e_alu = ref_alu(f); end
        else if (ph == "ALUWB") begin e_rd = 1; e_rw = 1; end
        else if (ph == "BREX") begin
            e_sa = 1; e_alu = 3'b110; e_ps = 2'b01;
            e_pcen = (o == BEQ) ? z : !z;
        end
        else if (ph == "ADDIWB") e_rw = 1;
        else if (ph == "JEX") begin e_ps = 2'b10; e_pcen = 1; end
        return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_sa, e_sb, e_ps, e_pcen, e_alu, e_ill};
    endfunction

    // Run one instruction through all its phases, checking every cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int fstall, input int mstall,
                             input logic zv, input string tag);
        string q[$];
        logic [15:0] exp_w;
        int nst;
        q.push_back("FETCH");
        q.push_back("DECODE");
        if (o == LW) begin q.push_back("MEMADR"); q.push_back("MEMRD"); q.push_back("MEMWB"); end
        else if (o == SW) begin q.push_back("MEMADR"); q.push_back("MEMWR"); end
        else if (o == RT) begin q.push_back("RTYPEEX"); q.push_back("ALUWB"); end
        else if (o == BEQ || o == BNE) q.push_back("BREX");
        else if (o == ADDI) begin q.push_back("ADDIEX"); q.push_back("ADDIWB"); end
        else if (o == JMP) q.push_back("JEX");
        foreach (q[i]) begin
            if (q[i] == "FETCH") nst = fstall;
            else if (q[i] == "MEMRD" || q[i] == "MEMWR") nst = mstall;
            else nst = 0;
            for (int s = 0; s <= nst; s++) begin
                @(negedge clk);
                op = o;
                funct = f;
                zero = zv;
                if (q[i] == "FETCH" || q[i] == "MEMRD" || q[i] == "MEMWR")
                    memready = (s == nst);
                else
                    memready = 1'($urandom_range(0, 1));
                #1;
                exp_w = expect_word(q[i], memready, zero, o, f);
                checks++;
                if (act_w !== exp_w) begin
                    errors++;
                    $display("FAIL %s %s cyc%0d actual=%h required=%h", tag, q[i], s, act_w, exp_w);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp_w;
        reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0; memready = 1'b1;
        #1;
        exp_w = expect_word("FETCH", 1'b1, 1'b0, op, funct);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("FAIL reset_mr1 actual=%h required=%h", act_w, exp_w);
        end
        memready = 1'b0;
        #1;
        exp_w = expect_word("FETCH", 1'b0, 1'b0, op, funct);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("FAIL reset_mr0 actual=%h required=%h", act_w, exp_w);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(LW, funct_tab[0], 0, 0, 1'b0, "lw");
        run_instr(LW, funct_tab[1], 2, 1, 1'b1, "lw_stall");
    endtask

    task automatic test_sw_stall();
        run_instr(SW, funct_tab[2], 0, 3, 1'b0, "sw_stall");
    endtask

    task automatic test_branch();
        run_instr(BEQ, funct_tab[0], 0, 0, 1'b1, "beq_z1");
        run_instr(BEQ, funct_tab[0], 0, 0, 1'b0, "beq_z0");
        run_instr(BNE, funct_tab[0], 0, 0, 1'b1, "bne_z1");
        run_instr(BNE, funct_tab[0], 0, 0, 1'b0, "bne_z0");
    endtask

    task automatic test_rtype();
        for (int k = 0; k < 5; k++) run_instr(RT, funct_tab[k], 0, 0, 1'b0, "rtype");
        run_instr(ADDI, funct_tab[3], 0, 0, 1'b0, "addi");
        run_instr(JMP, funct_tab[4], 0, 0, 1'b1, "j");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, funct_tab[0], 0, 0, 1'b0, "illegal_3f");
        run_instr(6'b000001, funct_tab[0], 1, 0, 1'b1, "illegal_01");
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_w;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            op = LW; funct = funct_tab[0]; memready = 1'b1; zero = 1'b0;
        end
        #1;
        exp_w = expect_word("MEMRD", 1'b1, 1'b0, LW, funct_tab[0]);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("FAIL rstmid_memrd actual=%h required=%h", act_w, exp_w);
        end
        reset = 1'b1;
        #1;
        exp_w = expect_word("FETCH", 1'b1, 1'b0, LW, funct_tab[0]);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("FAIL rstmid_async actual=%h required=%h", act_w, exp_w);
        end
        @(posedge clk); @(negedge clk);
        memready = 1'b0;
        #1;
        exp_w = expect_word("FETCH", 1'b0, 1'b0, LW, funct_tab[0]);
        checks++;
        if (act_w !== exp_w) begin
            errors++; $display("FAIL rstmid_hold actual=%h required=%h", act_w, exp_w);
        end
        reset = 1'b0;
        run_instr(ADDI, funct_tab[0], 0, 0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7] = '{LW, SW, RT, BEQ, BNE, ADDI, JMP};
        logic [5:0] o;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                o = 6'($urandom_range(0, 63));
                while (is_legal(o)) o = 6'($urandom_range(0, 63));
            end else begin
                o = ops[$urandom_range(0, 6)];
            end
            run_instr(o, funct_tab[$urandom_range(0, 4)], $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch();
        test_rtype();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
